rc4_key_search_ctrl: RTL and testbench

RC4_KEY_SEARCH_CTRL -- requirements
Module: rc4_key_search_ctrl

---
 rtl/rc4_pkg.sv | 14 +
 rtl/rc4_key_search_ctrl_if.sv | 31 +++
 rtl/rc4_core_slot.sv | 56 +++++
 rtl/rc4_key_search_ctrl.sv | 118 +++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-search controller and its per-core slots.
package rc4_pkg;

  localparam int KEY_WIDTH_DEFAULT = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Bus between the key-search controller (master) and its bank of RC4 decrypt cores (slave).
interface rc4_key_search_ctrl_if
  import rc4_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT
);

  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0]           core_abort;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_valid;

  modport master (
    output core_start,
    output core_key,
    output core_abort,
    input  core_done,
    input  core_valid
  );

  modport slave (
    input  core_start,
    input  core_key,
    input  core_abort,
    output core_done,
    output core_valid
  );

endinterface

// File: rtl/rc4_core_slot.sv
// Key counter and idle flag for one decrypt core; walks keys SLOT_INDEX, +NUM_CORES, ... up to KEY_MAX.
module rc4_core_slot
  import rc4_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEFAULT,
  parameter int KEY_MAX    = 2**KEY_WIDTH-1,
  parameter int NUM_CORES  = 2,
  parameter int SLOT_INDEX = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 halt,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 active,
  output logic                 start_pulse
);

  localparam logic [KEY_WIDTH:0] KEY_LIMIT = (KEY_WIDTH+1)'(KEY_MAX);
  localparam logic [KEY_WIDTH:0] STRIDE    = (KEY_WIDTH+1)'(NUM_CORES);
  localparam bit                 IN_RANGE  = (SLOT_INDEX <= KEY_MAX);

  // One extra bit so a step past the top of the key space is seen as out of range, not wrapped.
  logic [KEY_WIDTH:0] key_next;
  assign key_next = {1'b0, key} + STRIDE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key         <= '0;
      active      <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (load) begin
        if (IN_RANGE) begin
          key         <= KEY_WIDTH'(SLOT_INDEX);
          active      <= 1'b1;
          start_pulse <= 1'b1;
        end else begin
          active <= 1'b0;
        end
      end else if (halt) begin
        active <= 1'b0;
      end else if (advance) begin
        if (key_next <= KEY_LIMIT) begin
          key         <= key_next[KEY_WIDTH-1:0];
          start_pulse <= 1'b1;
        end else begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search: dispatches interleaved keys to NUM_CORES cores, stops on the first valid plaintext.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT,
  parameter int KEY_MAX   = 2**KEY_WIDTH-1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  rc4_key_search_ctrl_if.master  core_bus,
  output logic [KEY_WIDTH-1:0]   correct_key,
  output logic                   correct_key_found,
  output logic                   search_exhausted,
  output logic                   busy,
  output logic [KEY_WIDTH:0]     keys_tried
);

  state_t state;
  logic   start_d;
  logic   start_edge, dispatch_go, in_run, any_win, any_active;

  logic [NUM_CORES-1:0] slot_active, slot_start, accepted, win_vec, slot_advance;
  logic [KEY_WIDTH-1:0] slot_key [NUM_CORES];
  logic [KEY_WIDTH-1:0] win_key;
  logic [KEY_WIDTH:0]   done_count;

  assign start_edge  = start & ~start_d;
  assign dispatch_go = start_edge &&
                       (state == ST_IDLE || state == ST_FOUND || state == ST_EXHAUSTED);
  assign in_run      = (state == ST_RUN);

  // Only done pulses from busy slots during RUN count; everything else is stale or spurious.
  assign accepted     = in_run ? (core_bus.core_done & slot_active) : '0;
  assign win_vec      = accepted & core_bus.core_valid;
  assign any_win      = |win_vec;
  assign any_active   = |slot_active;
  assign slot_advance = any_win ? '0 : (accepted & ~core_bus.core_valid);

  // Descending scan so the lowest-index winner is the last assignment and takes priority.
  always_comb begin
    win_key    = '0;
    done_count = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (win_vec[i]) win_key = slot_key[i];
      done_count = done_count + {{KEY_WIDTH{1'b0}}, accepted[i]};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
      rc4_core_slot #(
        .KEY_WIDTH  (KEY_WIDTH),
        .KEY_MAX    (KEY_MAX),
        .NUM_CORES  (NUM_CORES),
        .SLOT_INDEX (gi)
      ) u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (dispatch_go),
        .advance     (slot_advance[gi]),
        .halt        (any_win),
        .key         (slot_key[gi]),
        .active      (slot_active[gi]),
        .start_pulse (slot_start[gi])
      );
      assign core_bus.core_key[gi*KEY_WIDTH +: KEY_WIDTH] = slot_key[gi];
    end
  endgenerate

  assign core_bus.core_start = slot_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      start_d             <= 1'b0;
      correct_key         <= '0;
      correct_key_found   <= 1'b0;
      search_exhausted    <= 1'b0;
      busy                <= 1'b0;
      keys_tried          <= '0;
      core_bus.core_abort <= '0;
    end else begin
      start_d             <= start;
      core_bus.core_abort <= '0;
      case (state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (dispatch_go) begin
            state             <= ST_DISPATCH;
            busy              <= 1'b1;
            correct_key       <= '0;
            correct_key_found <= 1'b0;
            search_exhausted  <= 1'b0;
            keys_tried        <= '0;
          end
        end
        ST_DISPATCH: state <= ST_RUN;
        ST_RUN: begin
          keys_tried <= keys_tried + done_count;
          if (any_win) begin
            state               <= ST_FOUND;
            busy                <= 1'b0;
            correct_key         <= win_key;
            correct_key_found   <= 1'b1;
            core_bus.core_abort <= '1;
          end else if (!any_active) begin
            state            <= ST_EXHAUSTED;
            busy             <= 1'b0;
            search_exhausted <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: three configurations, behavioural decrypt cores and a cycle-level vector table.
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DUT A: 2 cores, 3-bit keys, KEY_MAX = 7 (top of key space)
  logic       start_a, found_a, exh_a, busy_a;
  logic [2:0] ckey_a;
  logic [3:0] tried_a;
  rc4_key_search_ctrl_if #(.NUM_CORES(2), .KEY_WIDTH(3)) bus_a ();
  rc4_key_search_ctrl #(.NUM_CORES(2), .KEY_WIDTH(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .core_bus(bus_a),
    .correct_key(ckey_a), .correct_key_found(found_a), .search_exhausted(exh_a),
    .busy(busy_a), .keys_tried(tried_a));

  // DUT B: 4 cores, KEY_MAX = 6
  logic       start_b, found_b, exh_b, busy_b;
  logic [3:0] ckey_b;
  logic [4:0] tried_b;
  rc4_key_search_ctrl_if #(.NUM_CORES(4), .KEY_WIDTH(4)) bus_b ();
  rc4_key_search_ctrl #(.NUM_CORES(4), .KEY_WIDTH(4), .KEY_MAX(6)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .core_bus(bus_b),
    .correct_key(ckey_b), .correct_key_found(found_b), .search_exhausted(exh_b),
    .busy(busy_b), .keys_tried(tried_b));

  // DUT C: 3 cores, KEY_MAX = 4
  logic       start_c, found_c, exh_c, busy_c;
  logic [3:0] ckey_c;
  logic [4:0] tried_c;
  rc4_key_search_ctrl_if #(.NUM_CORES(3), .KEY_WIDTH(4)) bus_c ();
  rc4_key_search_ctrl #(.NUM_CORES(3), .KEY_WIDTH(4), .KEY_MAX(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .core_bus(bus_c),
    .correct_key(ckey_c), .correct_key_found(found_c), .search_exhausted(exh_c),
    .busy(busy_c), .keys_tried(tried_c));

  // Behavioural cores: latch key on core_start, report done after lat cycles, valid if key is in vset.
  bit          a_auto;
  logic [1:0]  a_done_r, a_valid_r, a_man_done, a_man_valid;
  logic [15:0] a_vset, b_vset, c_vset;
  int a_lat [2];  int a_cnt [2];  logic [2:0] a_key [2];  int a_issue [2][16];
  int a_abort_pulses, a_abort_bad;
  logic [3:0] b_done_r, b_valid_r;
  int b_lat [4];  int b_cnt [4];  logic [3:0] b_key [4];  int b_issue [4][16];
  logic [2:0] c_done_r, c_valid_r;
  int c_lat [3];  int c_cnt [3];  logic [3:0] c_key [3];  int c_issue [3][16];

  assign bus_a.core_done  = a_auto ? a_done_r  : a_man_done;
  assign bus_a.core_valid = a_auto ? a_valid_r : a_man_valid;
  assign bus_b.core_done  = b_done_r;
  assign bus_b.core_valid = b_valid_r;
  assign bus_c.core_done  = c_done_r;
  assign bus_c.core_valid = c_valid_r;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin a_cnt[i] <= 0; a_done_r[i] <= 1'b0; a_valid_r[i] <= 1'b0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        a_done_r[i] <= 1'b0; a_valid_r[i] <= 1'b0;
        if (bus_a.core_abort[i]) a_cnt[i] <= 0;
        else if (bus_a.core_start[i]) begin
          a_key[i] <= bus_a.core_key[i*3 +: 3];
          a_issue[i][bus_a.core_key[i*3 +: 3]] <= a_issue[i][bus_a.core_key[i*3 +: 3]] + 1;
          a_cnt[i] <= a_lat[i];
        end else if (a_cnt[i] == 1) begin
          a_cnt[i] <= 0; a_done_r[i] <= 1'b1; a_valid_r[i] <= a_vset[a_key[i]];
        end else if (a_cnt[i] > 1) a_cnt[i] <= a_cnt[i] - 1;
      end
      if (bus_a.core_abort != 2'b00) begin
        a_abort_pulses <= a_abort_pulses + 1;
        if (bus_a.core_abort != 2'b11) a_abort_bad <= a_abort_bad + 1;
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin b_cnt[i] <= 0; b_done_r[i] <= 1'b0; b_valid_r[i] <= 1'b0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        b_done_r[i] <= 1'b0; b_valid_r[i] <= 1'b0;
        if (bus_b.core_abort[i]) b_cnt[i] <= 0;
        else if (bus_b.core_start[i]) begin
          b_key[i] <= bus_b.core_key[i*4 +: 4];
          b_issue[i][bus_b.core_key[i*4 +: 4]] <= b_issue[i][bus_b.core_key[i*4 +: 4]] + 1;
          b_cnt[i] <= b_lat[i];
        end else if (b_cnt[i] == 1) begin
          b_cnt[i] <= 0; b_done_r[i] <= 1'b1; b_valid_r[i] <= b_vset[b_key[i]];
        end else if (b_cnt[i] > 1) b_cnt[i] <= b_cnt[i] - 1;
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin c_cnt[i] <= 0; c_done_r[i] <= 1'b0; c_valid_r[i] <= 1'b0; end
    end else begin
      for (int i = 0; i < 3; i++) begin
        c_done_r[i] <= 1'b0; c_valid_r[i] <= 1'b0;
        if (bus_c.core_abort[i]) c_cnt[i] <= 0;
        else if (bus_c.core_start[i]) begin
          c_key[i] <= bus_c.core_key[i*4 +: 4];
          c_issue[i][bus_c.core_key[i*4 +: 4]] <= c_issue[i][bus_c.core_key[i*4 +: 4]] + 1;
          c_cnt[i] <= c_lat[i];
        end else if (c_cnt[i] == 1) begin
          c_cnt[i] <= 0; c_done_r[i] <= 1'b1; c_valid_r[i] <= c_vset[c_key[i]];
        end else if (c_cnt[i] > 1) c_cnt[i] <= c_cnt[i] - 1;
      end
    end
  end

  // Cycle-level vectors for DUT A: inputs in cycle k, expected registered outputs one edge later.
  typedef struct {
    logic       st;
    logic [1:0] dn;
    logic [1:0] vl;
    logic [1:0] e_start;
    logic [5:0] e_keys;   // {key1, key0}
    logic [1:0] e_abort;
    logic       e_found;
    logic       e_exh;
    logic       e_busy;
    logic [3:0] e_tried;
    logic [2:0] e_ckey;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic wait_end(input int which, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      case (which)
        0:       seen = found_a | exh_a;
        1:       seen = found_b | exh_b;
        default: seen = found_c | exh_c;
      endcase
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no end of search, required found or exhausted", name);
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which) 1: start_b = 1'b1; default: start_c = 1'b1; endcase
    @(negedge clk);
    start_b = 1'b0; start_c = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_a [2][16];
    int snap_b [4][16];
    int snap_c [3][16];
    int abort_snap, mism, exp_n;

    tbl[0] = '{1'b1, 2'b00, 2'b00, 2'b11, 6'o10, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0};
    tbl[1] = '{1'b1, 2'b00, 2'b00, 2'b00, 6'o10, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0};
    tbl[2] = '{1'b0, 2'b01, 2'b00, 2'b01, 6'o12, 2'b00, 1'b0, 1'b0, 1'b1, 4'd1, 3'd0};
    tbl[3] = '{1'b0, 2'b10, 2'b00, 2'b10, 6'o32, 2'b00, 1'b0, 1'b0, 1'b1, 4'd2, 3'd0};
    tbl[4] = '{1'b0, 2'b11, 2'b00, 2'b11, 6'o54, 2'b00, 1'b0, 1'b0, 1'b1, 4'd4, 3'd0};
    tbl[5] = '{1'b1, 2'b00, 2'b00, 2'b00, 6'o54, 2'b00, 1'b0, 1'b0, 1'b1, 4'd4, 3'd0};
    tbl[6] = '{1'b0, 2'b01, 2'b00, 2'b01, 6'o56, 2'b00, 1'b0, 1'b0, 1'b1, 4'd5, 3'd0};
    tbl[7] = '{1'b0, 2'b10, 2'b10, 2'b00, 6'o56, 2'b11, 1'b1, 1'b0, 1'b0, 4'd6, 3'd5};
    tbl[8] = '{1'b0, 2'b01, 2'b01, 2'b00, 6'o56, 2'b00, 1'b1, 1'b0, 1'b0, 4'd6, 3'd5};
    tbl[9] = '{1'b1, 2'b00, 2'b00, 2'b11, 6'o10, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0};

    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    a_auto = 1'b0; a_man_done = 2'b00; a_man_valid = 2'b00;
    a_vset = '0; b_vset = '0; c_vset = '0;
    a_lat[0] = 3; a_lat[1] = 3;
    for (int i = 0; i < 4; i++) b_lat[i] = 2 + i;
    c_lat[0] = 2; c_lat[1] = 5; c_lat[2] = 3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_start", 32'(bus_a.core_start), 32'(0));
    chk("rst_a_keys",  32'(bus_a.core_key),   32'(0));
    chk("rst_a_abort", 32'(bus_a.core_abort), 32'(0));
    chk("rst_a_flags", 32'({found_a, exh_a, busy_a}), 32'(0));
    chk("rst_a_tried", 32'(tried_a), 32'(0));
    chk("rst_b_state", 32'({bus_b.core_start, busy_b, tried_b, ckey_b}), 32'(0));
    chk("rst_c_state", 32'({bus_c.core_start, busy_c, tried_c, ckey_c}), 32'(0));
    $display("[TB] reset state checked");

    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      start_a = tbl[k].st; a_man_done = tbl[k].dn; a_man_valid = tbl[k].vl;
      @(posedge clk); #1;
      chk($sformatf("v%0d_start", k), 32'(bus_a.core_start), 32'(tbl[k].e_start));
      chk($sformatf("v%0d_keys", k),  32'(bus_a.core_key),   32'(tbl[k].e_keys));
      chk($sformatf("v%0d_abort", k), 32'(bus_a.core_abort), 32'(tbl[k].e_abort));
      chk($sformatf("v%0d_found", k), 32'(found_a), 32'(tbl[k].e_found));
      chk($sformatf("v%0d_exh", k),   32'(exh_a),   32'(tbl[k].e_exh));
      chk($sformatf("v%0d_busy", k),  32'(busy_a),  32'(tbl[k].e_busy));
      chk($sformatf("v%0d_tried", k), 32'(tried_a), 32'(tbl[k].e_tried));
      chk($sformatf("v%0d_ckey", k),  32'(ckey_a),  32'(tbl[k].e_ckey));
      $display("[TB] vec %0d st=%b done=%b valid=%b -> core_start=%b keys=%o tried=%0d found=%b",
               k, tbl[k].st, tbl[k].dn, tbl[k].vl, bus_a.core_start, bus_a.core_key, tried_a, found_a);
    end

    // Move A into RUN with some progress, then pull reset in the middle of a cycle.
    @(negedge clk); start_a = 1'b0; a_man_done = 2'b00;
    @(negedge clk); a_man_done = 2'b11; a_man_valid = 2'b00;
    @(negedge clk); a_man_done = 2'b00;
    @(posedge clk); #1;
    chk("prerst_busy",  32'(busy_a),  32'(1));
    chk("prerst_tried", 32'(tried_a), 32'(2));
    abort_snap = a_abort_pulses;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_start", 32'(bus_a.core_start), 32'(0));
    chk("midrst_keys",  32'(bus_a.core_key),   32'(0));
    chk("midrst_abort", 32'(bus_a.core_abort), 32'(0));
    chk("midrst_flags", 32'({found_a, exh_a, busy_a}), 32'(0));
    chk("midrst_tried", 32'(tried_a), 32'(0));
    chk("midrst_ckey",  32'(ckey_a),  32'(0));
    $display("[TB] reset during RUN: keys=%o tried=%0d busy=%b", bus_a.core_key, tried_a, busy_a);
    @(negedge clk);
    reset_n = 1'b1;
    a_auto = 1'b1;
    a_vset = 16'h0020;
    chk("midrst_no_abort", 32'(a_abort_pulses - abort_snap), 32'(0));

    // Fresh search after reset; valid only for key 5.
    abort_snap = a_abort_pulses;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    chk("redispatch_start", 32'(bus_a.core_start), 32'(2'b11));
    chk("redispatch_keys",  32'(bus_a.core_key),   32'(6'o10));
    @(negedge clk); start_a = 1'b0;
    wait_end(0, "a_find5");
    repeat (2) @(posedge clk);
    #1;
    chk("a_find5_found", 32'(found_a), 32'(1));
    chk("a_find5_exh",   32'(exh_a),   32'(0));
    chk("a_find5_ckey",  32'(ckey_a),  32'(5));
    chk("a_find5_tried", 32'(tried_a), 32'(6));
    chk("a_find5_aborts", 32'(a_abort_pulses - abort_snap), 32'(1));
    chk("a_find5_abort_val", 32'(a_abort_bad), 32'(0));
    $display("[TB] A find key 5: ckey=%0d tried=%0d aborts=%0d", ckey_a, tried_a, a_abort_pulses - abort_snap);

    // Full sweep of a 3-bit key space: key 7 + 2 must not wrap back to 1.
    a_vset = '0; a_lat[0] = 2; a_lat[1] = 3;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 16; k++) snap_a[i][k] = a_issue[i][k];
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_end(0, "a_sweep");
    repeat (4) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++) begin
        exp_n = (k <= 7 && k % 2 == i) ? 1 : 0;
        if (a_issue[i][k] - snap_a[i][k] != exp_n) mism++;
      end
    chk("a_sweep_issue_map", 32'(mism), 32'(0));
    chk("a_sweep_exh",   32'(exh_a),   32'(1));
    chk("a_sweep_found", 32'(found_a), 32'(0));
    chk("a_sweep_tried", 32'(tried_a), 32'(8));
    chk("a_sweep_busy",  32'(busy_a),  32'(0));
    $display("[TB] A sweep: exhausted=%b tried=%0d map_errors=%0d", exh_a, tried_a, mism);

    // B: four cores, no valid key, unequal latencies.
    for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) snap_b[i][k] = b_issue[i][k];
    pulse_start(1);
    wait_end(1, "b_exhaust");
    repeat (4) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++) begin
        exp_n = (k <= 6 && k % 4 == i) ? 1 : 0;
        if (b_issue[i][k] - snap_b[i][k] != exp_n) mism++;
      end
    chk("b_exhaust_issue_map", 32'(mism), 32'(0));
    chk("b_exhaust_tried", 32'(tried_b), 32'(7));
    chk("b_exhaust_exh",   32'(exh_b),   32'(1));
    chk("b_exhaust_found", 32'(found_b), 32'(0));
    $display("[TB] B exhaust: exhausted=%b tried=%0d map_errors=%0d", exh_b, tried_b, mism);

    // B: cores 1 and 3 valid in the same cycle; lowest index must win.
    b_vset = 16'h000A;
    for (int i = 0; i < 4; i++) b_lat[i] = 4;
    pulse_start(1);
    #1;
    chk("b_restart_clears", 32'({exh_b, found_b}), 32'(0));
    wait_end(1, "b_tie");
    #1;
    chk("b_tie_ckey",  32'(ckey_b),  32'(1));
    chk("b_tie_found", 32'(found_b), 32'(1));
    chk("b_tie_exh",   32'(exh_b),   32'(0));
    chk("b_tie_tried", 32'(tried_b), 32'(4));
    $display("[TB] B tie: ckey=%0d tried=%0d", ckey_b, tried_b);

    // C: three cores over keys 0..4.
    for (int i = 0; i < 3; i++) for (int k = 0; k < 16; k++) snap_c[i][k] = c_issue[i][k];
    pulse_start(2);
    wait_end(2, "c_sweep");
    repeat (4) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++) begin
        exp_n = (k <= 4 && k % 3 == i) ? 1 : 0;
        if (c_issue[i][k] - snap_c[i][k] != exp_n) mism++;
      end
    chk("c_sweep_issue_map", 32'(mism), 32'(0));
    chk("c_sweep_tried", 32'(tried_c), 32'(5));
    chk("c_sweep_exh",   32'(exh_c),   32'(1));
    chk("c_sweep_found", 32'(found_c), 32'(0));
    $display("[TB] C sweep: exhausted=%b tried=%0d map_errors=%0d", exh_c, tried_c, mism);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
